// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - selectable static/bimodal/gshare branch predictor with BTB, speculative GHR and accuracy stats
module branch_predict_unit #(
    parameter int MODE      = 2,
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 10,
    parameter int BTB_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_valid,
    input  logic                 fetch_stall,
    input  logic [31:0]          fetch_pc,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic                 pred_btb_hit,
    output logic [GHR_W-1:0]     pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [GHR_W-1:0]     upd_ghr,
    input  logic                 upd_is_branch,
    input  logic                 upd_is_jump,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_mispredict,
    output logic [CNT_W-1:0]     stat_predictions,
    output logic [CNT_W-1:0]     stat_correct
);
    localparam int TAG_W = 32 - BTB_IDX_W - 2;
    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic [1:0]        pht_q [PHT_N];
    logic [BTB_N-1:0]  btb_valid_q;
    logic [BTB_N-1:0]  btb_jump_q;
    logic [TAG_W-1:0]  btb_tag_q [BTB_N];
    logic [31:0]       btb_target_q [BTB_N];
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [CNT_W-1:0]  stat_pred_q, stat_pred_d;
    logic [CNT_W-1:0]  stat_corr_q, stat_corr_d;

    logic [BTB_IDX_W-1:0] f_btb_idx, u_btb_idx;
    logic [1:0]           f_ctr, u_ctr, pht_upd_d;
    logic [PHT_IDX_W-1:0] u_pht_idx;
    logic                 u_branch, u_jump, u_ctl, pht_we, btb_we;
    logic [3:0]           pc_lsb_unused;

    function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [31:0] pc, input logic [GHR_W-1:0] ghr);
        logic [PHT_IDX_W-1:0] ext;
        ext = PHT_IDX_W'(ghr);
        return (MODE == 2) ? (pc[PHT_IDX_W+1:2] ^ ext) : pc[PHT_IDX_W+1:2];
    endfunction

    assign pc_lsb_unused = {fetch_pc[1:0], upd_pc[1:0]};

    always_comb begin
        f_btb_idx    = fetch_pc[BTB_IDX_W+1:2];
        f_ctr        = pht_q[pht_index(fetch_pc, ghr_q)];
        pred_btb_hit = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == fetch_pc[31:BTB_IDX_W+2]);
        pred_taken   = (MODE != 0) && pred_btb_hit && (btb_jump_q[f_btb_idx] || f_ctr[1]);
        pred_target  = pred_taken ? btb_target_q[f_btb_idx] : fetch_pc + 32'd4;
        pred_ghr     = ghr_q;
    end

    // Both flags set is illegal and resolves as a jump.
    always_comb begin
        u_jump    = upd_is_jump;
        u_branch  = upd_is_branch & ~upd_is_jump;
        u_ctl     = upd_valid & (u_jump | u_branch);
        u_pht_idx = pht_index(upd_pc, upd_ghr);
        u_ctr     = pht_q[u_pht_idx];
        pht_we    = (MODE != 0) && upd_valid && u_branch;
        pht_upd_d = u_ctr;
        if (upd_taken && u_ctr != 2'b11)
            pht_upd_d = u_ctr + 2'b01;
        else if (!upd_taken && u_ctr != 2'b00)
            pht_upd_d = u_ctr - 2'b01;
        u_btb_idx = upd_pc[BTB_IDX_W+1:2];
        btb_we    = upd_valid & ((u_branch & upd_taken) | u_jump);
    end

    // Resolved mispredict repairs history and wins over the fetch-side shift.
    always_comb begin
        ghr_d = ghr_q;
        if (fetch_valid && !fetch_stall && pred_btb_hit && !btb_jump_q[f_btb_idx])
            ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
        if (u_ctl && upd_mispredict)
            ghr_d = u_jump ? upd_ghr : {upd_ghr[GHR_W-2:0], upd_taken};
        stat_pred_d = stat_pred_q;
        stat_corr_d = stat_corr_q;
        if (u_ctl && stat_pred_q != '1)
            stat_pred_d = stat_pred_q + 1'b1;
        if (u_ctl && !upd_mispredict && stat_corr_q != '1)
            stat_corr_d = stat_corr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q       <= '0;
            stat_pred_q <= '0;
            stat_corr_q <= '0;
            btb_valid_q <= '0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
        end else begin
            ghr_q       <= ghr_d;
            stat_pred_q <= stat_pred_d;
            stat_corr_q <= stat_corr_d;
            if (btb_we) btb_valid_q[u_btb_idx] <= 1'b1;
            if (pht_we) pht_q[u_pht_idx] <= pht_upd_d;
        end
    end

    // Payload needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (btb_we && rst_n) begin
            btb_tag_q[u_btb_idx]    <= upd_pc[31:BTB_IDX_W+2];
            btb_target_q[u_btb_idx] <= upd_target;
            btb_jump_q[u_btb_idx]   <= u_jump;
        end
    end

    assign stat_predictions = stat_pred_q;
    assign stat_correct     = stat_corr_q;
endmodule
